uart_rx_oversample: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx_oversample.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART blocks.
// The default DATA_BITS/OVS_DIV here are used by the receiver top.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int OVS           = 16;
   localparam int SMP_FIRST     = 7;
   localparam int SMP_VOTE      = 9;
   localparam int BIT_END       = 15;

   localparam int OVS_DIV_DEF   = 651;
   localparam int DATA_BITS_DEF = 8;

   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every OVS_DIV clocks while enabled.
// Held at zero when disabled so the first tick lands a full period after enable.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int OVS_DIV = OVS_DIV_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int CW = (OVS_DIV > 2) ? $clog2(OVS_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(OVS_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == LAST);
   assign tick   = en & w_last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (!en || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x-oversampling UART receiver with majority vote and a single-entry hold register.
//   state | meaning
//   IDLE  | line idle, waiting for a low level on the synchronized input
//   START | inside start bit; a high vote at mid-bit is treated as a glitch
//   DATA  | shifting DATA_BITS data bits, LSB first
//   STOP  | waiting for mid-stop-bit vote, then back to IDLE
module uart_rx_oversample
   import uart_pkg::*;
#(
   parameter int OVS_DIV   = OVS_DIV_DEF,
   parameter int DATA_BITS = DATA_BITS_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       rx_ack,
   input  logic       err_clr,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_overrun,
   output logic       rx_frame_err,
   output logic       rx_busy
);

   localparam int SC_W = $clog2(OVS);
   localparam logic [SC_W-1:0] SC_S0   = SC_W'(SMP_FIRST);
   localparam logic [SC_W-1:0] SC_S1   = SC_W'(SMP_FIRST + 1);
   localparam logic [SC_W-1:0] SC_VOTE = SC_W'(SMP_VOTE);
   localparam logic [SC_W-1:0] SC_END  = SC_W'(BIT_END);
   localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

   uart_state_e     r_state;
   uart_state_e     w_state_nxt;

   logic            r_sync1;
   logic            r_sync2;
   logic            w_rs;
   logic            w_tick;
   logic            w_vote;

   logic [SC_W-1:0] r_sc;
   logic [1:0]      r_smp;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;

   logic            w_start;
   logic            w_bit_wr;
   logic            w_bit_next;
   logic            w_good;
   logic            w_bad;

   logic            r_good;
   logic            r_bad;
   logic [7:0]      r_data;
   logic            r_valid;
   logic            r_ovr;
   logic            r_ferr;
   logic            r_busy;
   logic            w_ovr_set;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rs = r_sync2;

   uart_baud_tick #(
      .OVS_DIV (OVS_DIV)
   ) u_baud_tick (
      .clk   (clk),
      .reset (reset),
      .en    (r_state != IDLE),
      .tick  (w_tick)
   );

   // Third sample is the live input at the vote tick, so no extra storage.
   assign w_vote = maj3({w_rs, r_smp});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_bit_wr    = 1'b0;
      w_bit_next  = 1'b0;
      w_good      = 1'b0;
      w_bad       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_rs) begin
               w_state_nxt = START;
               w_start     = 1'b1;
            end
         end
         START: begin
            if (w_tick) begin
               if (r_sc == SC_VOTE && w_vote) begin
                  w_state_nxt = IDLE;
               end else if (r_sc == SC_END) begin
                  w_state_nxt = DATA;
               end
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_sc == SC_VOTE) begin
                  w_bit_wr = 1'b1;
               end
               if (r_sc == SC_END) begin
                  if (r_bit_idx == LAST_BIT) begin
                     w_state_nxt = STOP;
                  end else begin
                     w_bit_next = 1'b1;
                  end
               end
            end
         end
         STOP: begin
            if (w_tick && r_sc == SC_VOTE) begin
               w_state_nxt = IDLE;
               w_good      = w_vote;
               w_bad       = ~w_vote;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sc      <= '0;
         r_smp     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else if (w_start) begin
         r_sc      <= '0;
         r_smp     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         if (w_tick) begin
            r_sc <= r_sc + 1'b1;
            if (r_sc == SC_S0) r_smp[0] <= w_rs;
            if (r_sc == SC_S1) r_smp[1] <= w_rs;
         end
         if (w_bit_wr)   r_shift[r_bit_idx] <= w_vote;
         if (w_bit_next) r_bit_idx <= r_bit_idx + 1'b1;
      end
   end

   assign w_ovr_set = r_good & r_valid & ~rx_ack;

   // Hold register updates one cycle after the stop vote; a set in the
   // same cycle as err_clr wins because it is assigned last.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_good  <= 1'b0;
         r_bad   <= 1'b0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
         r_ferr  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_good <= w_good;
         r_bad  <= w_bad;
         r_busy <= (w_state_nxt != IDLE);
         if (r_good) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (rx_ack) begin
            r_valid <= 1'b0;
         end
         if (err_clr) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
         end
         if (w_ovr_set) r_ovr  <= 1'b1;
         if (r_bad)     r_ferr <= 1'b1;
      end
   end

   assign rx_data      = r_data;
   assign rx_valid     = r_valid;
   assign rx_overrun   = r_ovr;
   assign rx_frame_err = r_ferr;
   assign rx_busy      = r_busy;

endmodule
